// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM servo display path: converter FSM states
// and BCD digit constants.
package pwm_pkg;

   typedef enum logic {
      IDLE,
      SHIFT
   } bcd_state_t;

   localparam int unsigned BCD_DIGIT_W    = 4;
   localparam int unsigned ADD3_THRESHOLD = 5;

endpackage : pwm_pkg

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so that
// the following left shift carries correctly into the next decimal digit.
module bcd_add3
   import pwm_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] digit_in,
   output logic [BCD_DIGIT_W-1:0] digit_out
);

   // Conditional +3, 4-bit wrap (never reached for legal digit values).
   always_comb begin
      digit_out = digit_in;
      if (digit_in >= BCD_DIGIT_W'(ADD3_THRESHOLD)) begin
         digit_out = digit_in + BCD_DIGIT_W'(3);
      end
   end

endmodule : bcd_add3

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle.
// Optional build macro BCD_AUTO_START_EN: when defined, a change of bin_in
// while idle requests a conversion without an external start pulse.
module bin_to_bcd_seq
   import pwm_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DIGITS = 3
) (
   input  logic                           clk,
   input  logic                           rst_n_a,
   input  logic [WIDTH-1:0]               bin_in,
   input  logic                           start,
   output logic                           busy,
   output logic                           done,
   output logic [DIGITS*BCD_DIGIT_W-1:0]  bcd_out
);

   localparam int unsigned SW = DIGITS * BCD_DIGIT_W;
   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   function automatic bit params_legal();
      longint unsigned p;
      p = 1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         p = p * 10;
      end
      return p > ((longint'(1) << WIDTH) - 1);
   endfunction

   generate
      if (!params_legal()) begin : g_bad_params
         $error("bin_to_bcd_seq: DIGITS too small to hold 2**WIDTH-1");
      end
   endgenerate

   bcd_state_t        state_q, state_d;
   logic [WIDTH-1:0]  shift_q, shift_d;
   logic [SW-1:0]     scratch_q, scratch_d;
   logic [SW-1:0]     scratch_adj;
   logic [CW-1:0]     count_q, count_d;
   logic              done_q, done_d;
   logic [SW-1:0]     bcd_q, bcd_d;
   logic              req;

`ifdef BCD_AUTO_START_EN
   logic [WIDTH-1:0]  last_bin_q, last_bin_d;
`endif

   generate
      for (genvar g = 0; g < DIGITS; g++) begin : g_add3
         bcd_add3 u_add3 (
            .digit_in  (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_out (scratch_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
         );
      end
   endgenerate

   // Next-state logic: accept in IDLE, one correct-and-shift per SHIFT edge.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      scratch_d = scratch_q;
      count_d   = count_q;
      done_d    = 1'b0;
      bcd_d     = bcd_q;
`ifdef BCD_AUTO_START_EN
      last_bin_d = last_bin_q;
      req        = start | (bin_in != last_bin_q);
`else
      req        = start;
`endif
      case (state_q)
         IDLE: begin
            if (req) begin
               shift_d   = bin_in;
               scratch_d = '0;
               count_d   = '0;
               state_d   = SHIFT;
`ifdef BCD_AUTO_START_EN
               last_bin_d = bin_in;
`endif
            end
         end
         SHIFT: begin
            {scratch_d, shift_d} = {scratch_adj, shift_q} << 1;
            count_d = count_q + 1'b1;
            // Final shift lands directly in the output register.
            if (count_q == CNT_LAST) begin
               bcd_d   = scratch_d;
               done_d  = 1'b1;
               count_d = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, datapath and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n_a) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         scratch_q <= '0;
         count_q   <= '0;
         done_q    <= 1'b0;
         bcd_q     <= '0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         scratch_q <= scratch_d;
         count_q   <= count_d;
         done_q    <= done_d;
         bcd_q     <= bcd_d;
      end
   end

`ifdef BCD_AUTO_START_EN
   // Last accepted input, used to detect switch changes while idle.
   always_ff @(posedge clk) begin
      if (!rst_n_a) begin
         last_bin_q <= '0;
      end else begin
         last_bin_q <= last_bin_d;
      end
   end
`endif

   assign busy    = (state_q == SHIFT);
   assign done    = done_q;
   assign bcd_out = bcd_q;

endmodule : bin_to_bcd_seq

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: a timing-level model pushes the
// expected result at accept time; a monitor pops it when done is seen.
module tb_bin_to_bcd_seq;

   localparam int unsigned WIDTH  = 8;
   localparam int unsigned DIGITS = 3;
   localparam int unsigned SW     = DIGITS * 4;

   logic             clk = 1'b0;
   logic             rst_n_a = 1'b0;
   logic             start = 1'b0;
   logic [WIDTH-1:0] bin_in = '0;
   logic             busy;
   logic             done;
   logic [SW-1:0]    bcd_out;

   bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .clk     (clk),
      .rst_n_a (rst_n_a),
      .bin_in  (bin_in),
      .start   (start),
      .busy    (busy),
      .done    (done),
      .bcd_out (bcd_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [SW-1:0] val;
      int unsigned   due;
   } exp_t;

   exp_t             sb[$];
   int unsigned      cyc = 0;
   int unsigned      checks = 0;
   int unsigned      errors = 0;
   int unsigned      remaining = 0;
   logic             busy_m = 1'b0;
   logic [SW-1:0]    bcd_m = '0;
   logic [SW-1:0]    pending = '0;
   logic [WIDTH-1:0] last_m = '0;
   logic             req_m;

   function automatic logic [SW-1:0] to_bcd(int unsigned v);
      logic [SW-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         r[i*4 +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Reference model: conversion takes WIDTH edges after accept.
   always @(posedge clk) begin
      cyc++;
      req_m = start;
`ifdef BCD_AUTO_START_EN
      req_m = start | (bin_in != last_m);
`endif
      if (!rst_n_a) begin
         remaining = 0;
         busy_m    = 1'b0;
         bcd_m     = '0;
         last_m    = '0;
         sb.delete();
      end else if (remaining > 0) begin
         remaining--;
         if (remaining == 0) begin
            busy_m = 1'b0;
            bcd_m  = pending;
         end
      end else if (req_m) begin
         pending   = to_bcd(32'(bin_in));
         remaining = WIDTH;
         busy_m    = 1'b1;
         last_m    = bin_in;
         sb.push_back('{val: pending, due: cyc + WIDTH});
      end
   end

   // Monitor: sample away from the active edge.
   always @(negedge clk) begin
      exp_t e;
      chk("busy", 32'(busy), 32'(busy_m));
      chk("bcd_out_hold", 32'(bcd_out), 32'(bcd_m));
      if (done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected done=0 at cycle %0d", cyc);
         end else begin
            e = sb.pop_front();
            chk("done_value", 32'(bcd_out), 32'(e.val));
            chk("done_cycle", cyc, e.due);
         end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
         checks++;
         errors++;
         $display("FAIL missing_done: got done=0 expected done=1 at cycle %0d", cyc);
         void'(sb.pop_front());
      end
   end

   task automatic tick(int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic conv(logic [WIDTH-1:0] v);
      bin_in = v;
      start  = 1'b1;
      tick(1);
      start  = 1'b0;
      tick(WIDTH + 2);
   endtask

   initial begin
      rst_n_a = 1'b0;
      tick(3);
      rst_n_a = 1'b1;
      tick(1);

      conv(8'd180);
      conv(8'd255);
      conv(8'd0);
      conv(8'd99);

      // Start re-pulsed and input changed while converting.
      bin_in = 8'd37;
      start  = 1'b1;
      tick(1);
      start  = 1'b0;
      tick(1);
      bin_in = 8'd200;
      start  = 1'b1;
      tick(1);
      start  = 1'b0;
      tick(2);
      start  = 1'b1;
      tick(1);
      start  = 1'b0;
      tick(WIDTH + 4);

      // Reset mid-conversion discards the result.
      bin_in = 8'd123;
      start  = 1'b1;
      tick(1);
      start  = 1'b0;
      tick(3);
      rst_n_a = 1'b0;
      tick(1);
      rst_n_a = 1'b1;
      tick(WIDTH + 2);
      conv(8'd45);

      // Start held high: back-to-back conversions.
      bin_in = 8'd10;
      start  = 1'b1;
      tick(4 * (WIDTH + 1));
      start  = 1'b0;
      tick(WIDTH + 2);

      // Input steps with no start (self-triggers only in auto-start builds).
      bin_in = 8'd0;
      tick(WIDTH + 3);
      bin_in = 8'd90;
      tick(3);
      bin_in = 8'd91;
      tick(2 * WIDTH + 6);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 600; i++) begin
         start   = ($urandom % 4 == 0);
         if ($urandom % 3 == 0) bin_in = WIDTH'($urandom);
         rst_n_a = ($urandom % 100 != 0);
         tick(1);
      end
      start   = 1'b0;
      rst_n_a = 1'b1;
      tick(2 * WIDTH + 4);

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_bin_to_bcd_seq

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble). It sits between the angle-switch input and the three `segmentos_7` digit decoders of the PWM servo design. It replaces combinational divide/modulo with a WIDTH-cycle iterative conversion. It takes the 8-bit angle setpoint and produces registered units/tens/hundreds digits plus a completion pulse.

## Interface
Parameters:
- WIDTH, 8: binary input width.
- DIGITS, 3: number of BCD digits produced. Must satisfy 10^DIGITS > 2^WIDTH − 1; an illegal combination is an elaboration error.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n_a  in  1  reset; one clock, reset is synchronous and active-low.
- bin_in  in  WIDTH  unsigned binary value, sampled only when a conversion is accepted.
- start  in  1  conversion request, level-sampled each edge.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when bcd_out has just been updated.
- bcd_out  out  DIGITS*4  result digits; [3:0] is units, [7:4] tens, [11:8] hundreds, and so on.

## Operation
- FSM states: IDLE, SHIFT.
- IDLE:
  - Conversion is accepted on an edge where state is IDLE and start=1.
  - On accept: latch bin_in into the shift register, clear the BCD scratch, set count=0, and move to SHIFT.
- SHIFT, one iteration per edge:
  - Every scratch digit ≥5 gets +3 (4-bit, no carry out).
  - Then {scratch, shift_reg} shifts left by 1.
  - count increments.
- When count reaches WIDTH−1 on an edge, that edge also:
  - loads the final scratch into bcd_out,
  - pulses done,
  - returns to IDLE.
- bcd_out holds its value between conversions. It is never exposed mid-conversion.
- start while busy=1 is ignored and not queued.
- bin_in changing during SHIFT has no effect.
- Reset (rst_n_a=0 at an edge), including mid-conversion:
  - state=IDLE, busy=0, done=0, bcd_out=0, scratch=0, count=0.
  - Any in-flight conversion is discarded.
- Arithmetic:
  - Scratch width is DIGITS*4.
  - Shift register width is WIDTH.
  - count width is clog2(WIDTH).
  - No intermediate value exceeds digit range, given the legal parameter check.

## Timing
- Accept at edge N: busy=1 after edge N.
- Result edge is N+WIDTH (8 for default). After that edge, bcd_out is valid, done=1 for exactly one cycle, and busy=0.
- Earliest next accept is edge N+WIDTH+1, which gives a throughput of one conversion per WIDTH+1 cycles.
- start held high continuously therefore converts back-to-back with a one-cycle IDLE gap.
- done and busy are never high in the same cycle.

## Configuration
- BCD_AUTO_START_EN:
  - Defined:
    - Adds register last_bin (reset 0).
    - An internal request is raised whenever state=IDLE and bin_in≠last_bin. It is ORed with start.
    - last_bin is loaded with bin_in on every accept.
    - Switch changes therefore self-trigger conversion with no external start. Holding bin_in constant causes no further conversions.
  - Undefined: conversions happen only on the start port, and last_bin is absent.

## Structure
- Shared package `pwm_pkg` holds:
  - the state encoding constants (IDLE, SHIFT),
  - BCD_DIGIT_W=4,
  - ADD3_THRESHOLD=5.
- One sub-module, `bcd_add3`: a 4-bit combinational digit correction (in ≥5 → in+3, else in). It is instantiated DIGITS times via generate.
- The FSM, shift/scratch registers, counter and output registers live in `bin_to_bcd_seq`.

## Test plan
- Reset, then bin_in=180 and a 1-cycle start → after 8 edges: done=1 once, bcd_out=12'h180, busy=0.
- bin_in=255, start → bcd_out=12'h255. Then bin_in=0, start → bcd_out=12'h000. Then bin_in=99 → 12'h099.
- Start with bin_in=37, pulse start again at cycles 2 and 5 while bin_in changes to 200 → single done, bcd_out=12'h037.
- Start with 123, assert rst_n_a=0 at cycle 4 for one edge → busy=0, done never pulses, bcd_out=0. A new start with 45 → 12'h045.
- start held high with bin_in=10 → done pulses every 9 cycles, busy low exactly one cycle between conversions.
- With BCD_AUTO_START_EN:
  - bin_in steps 0→90 with no start → after 8 edges, bcd_out=12'h090.
  - bin_in held at 90 → no further done.
  - bin_in changes to 91 during SHIFT → it converts immediately after returning to IDLE.
